// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding, default parameters and next-PC select for fetch_ctrl
package fetch_ctrl_pkg;
   typedef enum logic [1:0] {LOAD = 2'd0, START = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
   localparam int          IM_DEPTH_DEF     = 1024;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   function automatic logic [31:0] next_pc_sel(
      input logic br, input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
      input logic stall, input logic [31:0] pc, input logic [31:0] npc);
      return br ? bt : jmp ? jt : stall ? pc : npc;
   endfunction
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: loads a host program into instruction memory, then steers the fetch PC
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int          IM_DEPTH     = IM_DEPTH_DEF,
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LD_VALID,
   input  logic [31:0] LD_DATA,
   input  logic        LD_LAST,
   output logic        LD_READY,
   input  logic [31:0] PC,
   input  logic [31:0] NEXT_PC,
   input  logic        STALL,
   input  logic        BR_TAKEN,
   input  logic [31:0] BR_TARGET,
   input  logic        JMP,
   input  logic [31:0] JMP_TARGET,
   input  logic        HALT_REQ,
   output logic [31:0] NEW_PC,
   output logic        IM_WE,
   output logic [31:0] IM_WDATA,
   output logic        FLUSH,
   output logic        RUNNING,
   output logic        LD_ERR,
   output logic [10:0] LD_COUNT
);
   localparam logic [10:0] LAST_IDX = 11'(IM_DEPTH - 1);
   state_t state;
   always_ff @(posedge CLK)
      if (!RST) begin
         state    <= LOAD;
         LD_COUNT <= '0;
         LD_ERR   <= 1'b0;
         RUNNING  <= 1'b0;
      end else
         case (state)
            LOAD:
               if (LD_VALID) begin
                  LD_COUNT <= LD_COUNT + 11'd1;
                  if (LD_LAST)
                     state <= START;
                  else if (LD_COUNT == LAST_IDX) begin
                     state  <= HALT;
                     LD_ERR <= 1'b1;
                  end
               end
            START: begin
               state   <= RUN;
               RUNNING <= 1'b1;
            end
            RUN:
               if (HALT_REQ) begin
                  state   <= HALT;
                  RUNNING <= 1'b0;
               end
            default: ;
         endcase
   // Reset forces the fetch stage onto RESET_VECTOR so the next load starts there
   assign LD_READY = RST && state == LOAD;
   assign IM_WE    = LD_READY && LD_VALID;
   assign IM_WDATA = LD_DATA;
   assign FLUSH    = RST && (state == START || (state == RUN && (BR_TAKEN || JMP)));
   assign NEW_PC   = !RST            ? RESET_VECTOR :
                     state == LOAD   ? (LD_VALID ? NEXT_PC : PC) :
                     state == START  ? RESET_VECTOR :
                     state == RUN    ? next_pc_sel(BR_TAKEN, BR_TARGET, JMP, JMP_TARGET, STALL, PC, NEXT_PC) :
                     PC;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: random load/run episodes against a phase-level model of the fetch controller
module tb_fetch_ctrl;
   localparam int          DEPTH = 8;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam int P_LOAD = 0, P_START = 1, P_RUN = 2, P_HALT = 3;
   logic        CLK = 1'b0, RST = 1'b0, LD_VALID = 1'b0, LD_LAST = 1'b0;
   logic        STALL = 1'b0, BR_TAKEN = 1'b0, JMP = 1'b0, HALT_REQ = 1'b0;
   logic [31:0] LD_DATA = '0, PC = '0, BR_TARGET = '0, JMP_TARGET = '0;
   logic [31:0] NEXT_PC, NEW_PC, IM_WDATA;
   logic        LD_READY, IM_WE, FLUSH, RUNNING, LD_ERR;
   logic [10:0] LD_COUNT;
   assign NEXT_PC = PC + 32'd4;
   always #5 CLK = ~CLK;
   fetch_ctrl #(.IM_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
      .CLK(CLK), .RST(RST), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_LAST(LD_LAST),
      .LD_READY(LD_READY), .PC(PC), .NEXT_PC(NEXT_PC), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
      .BR_TARGET(BR_TARGET), .JMP(JMP), .JMP_TARGET(JMP_TARGET), .HALT_REQ(HALT_REQ),
      .NEW_PC(NEW_PC), .IM_WE(IM_WE), .IM_WDATA(IM_WDATA), .FLUSH(FLUSH), .RUNNING(RUNNING),
      .LD_ERR(LD_ERR), .LD_COUNT(LD_COUNT));
   int n_tests = 0, n_fail = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   int          phase = P_LOAD, count = 0;
   bit          err = 1'b0, known = 1'b0;
   logic [31:0] words[$];
   logic [31:0] mem[0:15];
   initial begin
      logic [31:0] e_pc, seen_pc, seen_addr, seen_data;
      logic        e_we, e_rdy, e_fl, seen_we;
      int          prev;
      for (int ep = 0; ep < 60; ep++)
         for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge CLK);
            RST        = !(cyc < int'($urandom_range(1, 2)) || $urandom_range(0, 99) == 0);
            LD_VALID   = $urandom_range(0, 9) < 7;
            LD_LAST    = $urandom_range(0, 5) == 0;
            LD_DATA    = $urandom;
            STALL      = $urandom_range(0, 3) == 0;
            BR_TAKEN   = $urandom_range(0, 6) == 0;
            JMP        = $urandom_range(0, 6) == 0;
            HALT_REQ   = $urandom_range(0, 19) == 0;
            BR_TARGET  = $urandom;
            JMP_TARGET = $urandom;
            #1;
            e_we = 1'b0; e_rdy = 1'b0; e_fl = 1'b0; e_pc = PC;
            if (!RST) e_pc = RV;
            else if (phase == P_LOAD) begin
               e_rdy = 1'b1; e_we = LD_VALID; e_pc = LD_VALID ? PC + 32'd4 : PC;
            end else if (phase == P_START) begin
               e_pc = RV; e_fl = 1'b1;
            end else if (phase == P_RUN) begin
               e_fl = BR_TAKEN || JMP;
               e_pc = BR_TAKEN ? BR_TARGET : JMP ? JMP_TARGET : STALL ? PC : PC + 32'd4;
            end
            if (known) begin
               check("new_pc", NEW_PC, e_pc);
               check("im_we", 32'(IM_WE), 32'(e_we));
               check("ld_ready", 32'(LD_READY), 32'(e_rdy));
               check("flush", 32'(FLUSH), 32'(e_fl));
               check("running", 32'(RUNNING), 32'(phase == P_RUN));
               check("ld_err", 32'(LD_ERR), 32'(err));
               check("ld_count", 32'(LD_COUNT), 32'(count));
               if (e_we) check("im_wdata", IM_WDATA, LD_DATA);
            end
            seen_pc = NEW_PC; seen_we = IM_WE; seen_addr = PC; seen_data = IM_WDATA;
            @(posedge CLK);
            if (seen_we && seen_addr < 32'd64) mem[seen_addr[5:2]] = seen_data;
            PC   = seen_pc;
            prev = phase;
            if (!RST) begin
               phase = P_LOAD; count = 0; err = 1'b0; known = 1'b1; words.delete();
            end else if (phase == P_LOAD && LD_VALID) begin
               count++;
               words.push_back(LD_DATA);
               if (LD_LAST) phase = P_START;
               else if (count == DEPTH) begin
                  phase = P_HALT; err = 1'b1;
               end
            end else if (phase == P_START) phase = P_RUN;
            else if (phase == P_RUN && HALT_REQ) phase = P_HALT;
            if (known && prev == P_LOAD && phase != P_LOAD)
               foreach (words[i]) check($sformatf("mem[%0d]", i), mem[i], words[i]);
         end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter IM_DEPTH, 1024, instruction-memory depth in 32-bit words.
REQ-002 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address after load.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-low reset; sampled only on rising CLK.
REQ-005 LD_VALID  in  1  host program word available.
REQ-006 LD_DATA  in  32  host program word.
REQ-007 LD_LAST  in  1  qualifies LD_VALID; marks final program word.
REQ-008 LD_READY  out  1  controller accepts a word this cycle.
REQ-009 PC  in  32  current fetch-stage PC.
REQ-010 NEXT_PC  in  32  PC+4 from fetch stage.
REQ-011 STALL  in  1  hold fetch (hazard from later stage).
REQ-012 BR_TAKEN / BR_TARGET  in  1 / 32  resolved taken branch and its target.
REQ-013 JMP / JMP_TARGET  in  1 / 32  jump request and its target.
REQ-014 HALT_REQ  in  1  stop fetching.
REQ-015 NEW_PC  out  32  PC value loaded by fetch stage at next edge.
REQ-016 IM_WE / IM_WDATA  out  1 / 32  instruction-memory write enable (address = PC) and data.
REQ-017 FLUSH  out  1  one-cycle kill of the in-flight fetched instruction.
REQ-018 RUNNING / LD_ERR  out  1 / 1  core-executing status; load-overflow error.
REQ-019 LD_COUNT  out  11  words written during current load (0..IM_DEPTH).

Function
REQ-020 States SHALL be LOAD, START, RUN, HALT; only state/counter/flags are registered; NEW_PC, IM_WE, IM_WDATA, LD_READY, FLUSH are combinational from state and inputs.
REQ-021 LOAD: LD_READY=1; on LD_VALID: IM_WE=1, IM_WDATA=LD_DATA, NEW_PC=NEXT_PC, LD_COUNT+1; without LD_VALID: IM_WE=0, NEW_PC=PC.
REQ-022 LOAD with LD_VALID&LD_LAST SHALL write that word and go to START next cycle.
REQ-023 If the accepted word makes LD_COUNT equal IM_DEPTH without LD_LAST, it SHALL be written, LD_ERR set, state to HALT; LD_READY=0 thereafter (no wrap, no overwrite of address 0).
REQ-024 START: NEW_PC=RESET_VECTOR, IM_WE=0, FLUSH=1, next state RUN (one cycle).
REQ-025 RUN: RUNNING=1, IM_WE=0, LD_READY=0; NEW_PC priority: BR_TAKEN->BR_TARGET, else JMP->JMP_TARGET, else STALL->PC, else NEXT_PC.
REQ-026 FLUSH SHALL be 1 in RUN exactly in cycles where BR_TAKEN or JMP is 1, regardless of STALL.
REQ-027 Redirect latency: target visible on PC one cycle after BR_TAKEN/JMP asserted.
REQ-028 HALT_REQ in RUN: next state HALT; that cycle's NEW_PC still follows REQ-025 (a simultaneous redirect completes).
REQ-029 HALT: NEW_PC=PC, RUNNING=0, FLUSH=0, IM_WE=0; exit only by reset.
REQ-030 HALT_REQ, STALL, BR_TAKEN, JMP SHALL be ignored in LOAD and START.
REQ-031 Target addresses are passed unmodified; no alignment check or masking.
REQ-032 LD_COUNT SHALL hold its final value through START/RUN/HALT until reset.

Reset
REQ-033 RST=0 at an edge: state LOAD, LD_COUNT=0, LD_ERR=0, RUNNING=0.
REQ-034 While RST=0 combinational outputs SHALL be NEW_PC=RESET_VECTOR, IM_WE=0, LD_READY=0, FLUSH=0, so PC reaches RESET_VECTOR before loading begins.
REQ-035 Reset mid-load or mid-run SHALL abandon the operation; the next load restarts at RESET_VECTOR and overwrites memory from there.

Structure
REQ-036 State encoding (2-bit), IM_DEPTH and RESET_VECTOR defaults SHALL reside in the shared common_param header.
REQ-037 Single module; no sub-module; the next-PC priority mux may be a local function.

Verification
REQ-038 Reset, then 3 words (LAST on 3rd) -> IM_WE on 3 cycles at PC 0,4,8; LD_COUNT=3; START FLUSH=1; RUN with PC=0.
REQ-039 RUN, BR_TAKEN=1 BR_TARGET=0x40 with JMP=1 JMP_TARGET=0x80 and STALL=1 -> NEW_PC=0x40, FLUSH=1 for one cycle.
REQ-040 RUN, STALL=1 for 3 cycles at PC=0x10 -> NEW_PC=0x10 each cycle, FLUSH=0; release -> PC=0x14.
REQ-041 IM_DEPTH=4, 4 words without LAST -> 4 writes, LD_ERR=1, HALT, LD_READY=0, 5th LD_VALID ignored.
REQ-042 HALT_REQ with JMP to 0x20 -> PC=0x20, then HALT, PC stays 0x20, RUNNING=0; RST=0 -> LOAD, LD_COUNT=0.
